// File: rtl/vga_stream_pkg.sv
// Shared types and constants for the VGA pixel-stream stages.
// Holds the face index enum, the fade FSM state enum and the stream geometry
// constants used by vga_fade_stage and vga_chan_scale.
package vga_stream_pkg;

    typedef enum logic [1:0] {
        FACE_WOLF  = 2'd0,
        FACE_P2    = 2'd1,
        FACE_TROLL = 2'd2
    } face_t;

    typedef enum logic [1:0] {
        ST_SHOW     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWAP     = 2'd2,
        ST_FADE_IN  = 2'd3
    } fade_state_t;

    localparam int CHAN_W     = 10;
    localparam int NUM_PIXELS = 307200;
    localparam int LEVEL_MAX  = 16;

endpackage

// File: rtl/vga_chan_scale.sv
// Combinational brightness scaler for one 10-bit colour channel.
// Ports:
//   chan_i  - input channel {8 colour bits, 2 padding bits}
//   level_i - brightness level 0..16 (16 = unity)
//   chan_o  - scaled channel, padding bits forced to zero
module vga_chan_scale
    import vga_stream_pkg::*;
#(
    parameter int LEVEL_W = 5
) (
    input  logic [CHAN_W-1:0]  chan_i,
    input  logic [LEVEL_W-1:0] level_i,
    output logic [CHAN_W-1:0]  chan_o
);

    logic [7:0]  c8;
    logic [12:0] prod;
    logic        unused_bits;

    assign c8   = chan_i[CHAN_W-1:2];
    assign prod = 13'(c8) * 13'(level_i);

    // Level 16 is a 4-bit left shift, so prod[11:4] returns c8 unchanged.
    // prod[12] can only be set by levels above 16, which never occur.
    assign chan_o = {prod[11:4], 2'b00};

    assign unused_bits = ^{chan_i[1:0], prod[12], prod[3:0]};

endmodule

// File: rtl/vga_fade_stage.sv
// Avalon-ST pixel stage between vga_face and the VGA output core.
// Scales every pixel by a per-frame brightness level and, when a new face is
// requested, fades to black over whole frames, swaps face_select during one
// black frame, then fades back in.
// Ports:
//   clk, reset_n            - clock, synchronous active-low reset
//   face_request            - requested face index
//   face_select             - face index driven to vga_face
//   snk_*                   - upstream Avalon-ST sink (data/sop/eop/valid/ready)
//   src_*                   - registered Avalon-ST source toward the VGA core
//   fade_busy               - high whenever the FSM is not in SHOW
//   frame_error             - sticky SOP/EOP position error
//   dbg_state, dbg_level    - FSM state and current brightness level
//
// Handshake: a beat transfers on a port when valid and ready are both high at
// a clk edge. snk_ready = ~src_valid | src_ready, so the single output
// register can always accept a new beat when it is empty or being drained;
// while src_valid & ~src_ready every src_* output holds.
module vga_fade_stage #(
    parameter int NUM_PIXELS      = 307200,
    parameter int CHAN_W          = 10,
    parameter int LEVEL_W         = 5,
    parameter int LEVEL_STEP      = 2,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            face_request,
    output logic [1:0]            face_select,
    input  logic [3*CHAN_W-1:0]   snk_data,
    input  logic                  snk_startofpacket,
    input  logic                  snk_endofpacket,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    output logic [3*CHAN_W-1:0]   src_data,
    output logic                  src_startofpacket,
    output logic                  src_endofpacket,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic                  fade_busy,
    output logic                  frame_error,
    output logic [1:0]            dbg_state,
    output logic [LEVEL_W-1:0]    dbg_level
);
    import vga_stream_pkg::fade_state_t;
    import vga_stream_pkg::ST_SHOW;
    import vga_stream_pkg::ST_FADE_OUT;
    import vga_stream_pkg::ST_SWAP;
    import vga_stream_pkg::ST_FADE_IN;
    import vga_stream_pkg::LEVEL_MAX;

    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int PC_W = 19;
    localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_STEP = LEVEL_W'(LEVEL_STEP);
    localparam logic [FC_W-1:0]    FC_LAST  = FC_W'(FRAMES_PER_STEP - 1);
    localparam logic [PC_W-1:0]    PC_LAST  = PC_W'(NUM_PIXELS - 1);

    fade_state_t          state_q, state_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [PC_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [1:0]           face_sel_q, face_sel_d;
    logic                 frame_err_q, frame_err_d;

    logic [3*CHAN_W-1:0]  src_data_q;
    logic                 src_sop_q, src_eop_q, src_valid_q;

    logic                 accept;
    logic                 eop;
    logic                 step_due;
    logic [LEVEL_W-1:0]   lvl_dn, lvl_up;
    logic [3*CHAN_W-1:0]  scaled;

    assign snk_ready = ~src_valid_q | src_ready;
    assign accept    = snk_valid & snk_ready;
    assign eop       = accept & snk_endofpacket;

    // Saturating level steps; the range is clamped to [0, LEVEL_MAX].
    assign lvl_dn   = (level_q <= LVL_STEP) ? '0 : level_q - LVL_STEP;
    assign lvl_up   = (level_q >= LVL_MAX - LVL_STEP) ? LVL_MAX : level_q + LVL_STEP;
    assign step_due = (frame_cnt_q == FC_LAST);

    for (genvar c = 0; c < 3; c++) begin : g_chan
        vga_chan_scale #(
            .LEVEL_W (LEVEL_W)
        ) u_scale (
            .chan_i  (snk_data[c*CHAN_W +: CHAN_W]),
            .level_i (level_q),
            .chan_o  (scaled[c*CHAN_W +: CHAN_W])
        );
    end

    // Fade FSM: every transition happens on an accepted EOP beat, so the
    // level is constant over a whole frame.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        face_sel_d  = face_sel_q;
        if (eop) begin
            case (state_q)
                ST_SHOW: begin
                    if (face_request != face_sel_q) begin
                        state_d     = ST_FADE_OUT;
                        frame_cnt_d = '0;
                    end
                end
                ST_FADE_OUT: begin
                    if (step_due) begin
                        frame_cnt_d = '0;
                        level_d     = lvl_dn;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                    if (level_d == '0) begin
                        state_d = ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    // The request is sampled only here, so changes during the
                    // fade-out are resolved on this one black frame.
                    face_sel_d  = face_request;
                    frame_cnt_d = '0;
                    state_d     = ST_FADE_IN;
                end
                ST_FADE_IN: begin
                    if (step_due) begin
                        frame_cnt_d = '0;
                        level_d     = lvl_up;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                    if (level_d == LVL_MAX) begin
                        state_d = ST_SHOW;
                    end
                end
                default: begin
                    state_d = ST_SHOW;
                end
            endcase
        end
    end

    // Framing monitor: never alters the stream, only flags bad SOP/EOP spacing.
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        frame_err_d = frame_err_q;
        if (accept) begin
            if (snk_startofpacket && (pix_cnt_q != '0)) begin
                frame_err_d = 1'b1;
            end
            if (snk_endofpacket && (pix_cnt_q != PC_LAST)) begin
                frame_err_d = 1'b1;
            end
            if (snk_endofpacket) begin
                pix_cnt_d = '0;
            end else if (snk_startofpacket) begin
                pix_cnt_d = PC_W'(1);
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_SHOW;
            level_q     <= LVL_MAX;
            frame_cnt_q <= '0;
            pix_cnt_q   <= '0;
            face_sel_q  <= 2'd0;
            frame_err_q <= 1'b0;
            src_data_q  <= '0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            face_sel_q  <= face_sel_d;
            frame_err_q <= frame_err_d;
            if (accept) begin
                src_data_q  <= scaled;
                src_sop_q   <= snk_startofpacket;
                src_eop_q   <= snk_endofpacket;
                src_valid_q <= 1'b1;
            end else if (src_ready) begin
                src_valid_q <= 1'b0;
            end
        end
    end

    assign face_select       = face_sel_q;
    assign src_data          = src_data_q;
    assign src_startofpacket = src_sop_q;
    assign src_endofpacket   = src_eop_q;
    assign src_valid         = src_valid_q;
    assign fade_busy         = (state_q != ST_SHOW);
    assign frame_error       = frame_err_q;
    assign dbg_state         = state_q;
    assign dbg_level         = level_q;

endmodule

// File: tb/tb_vga_fade_stage.sv
module tb_vga_fade_stage;

  localparam int NPIX = 16;
  localparam logic [29:0] PAD_MASK = 30'h3FCFF3FC;
  localparam logic [29:0] PAT1 = 30'h3FCFF00C;
  localparam logic [29:0] WHITE = {10'h3FC, 10'h3FC, 10'h3FC};
  localparam logic [29:0] HALF = {10'h1FC, 10'h1FC, 10'h1FC};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  face_request;
  logic [1:0]  face_select;
  logic [29:0] snk_data;
  logic        snk_startofpacket, snk_endofpacket, snk_valid, snk_ready;
  logic [29:0] src_data;
  logic        src_startofpacket, src_endofpacket, src_valid, src_ready;
  logic        fade_busy, frame_error;
  logic [1:0]  dbg_state;
  logic [4:0]  dbg_level;

  vga_fade_stage #(
    .NUM_PIXELS      (NPIX),
    .CHAN_W          (10),
    .LEVEL_W         (5),
    .LEVEL_STEP      (2),
    .FRAMES_PER_STEP (1)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .face_request      (face_request),
    .face_select       (face_select),
    .snk_data          (snk_data),
    .snk_startofpacket (snk_startofpacket),
    .snk_endofpacket   (snk_endofpacket),
    .snk_valid         (snk_valid),
    .snk_ready         (snk_ready),
    .src_data          (src_data),
    .src_startofpacket (src_startofpacket),
    .src_endofpacket   (src_endofpacket),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .fade_busy         (fade_busy),
    .frame_error       (frame_error),
    .dbg_state         (dbg_state),
    .dbg_level         (dbg_level)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int exp_level = 16;
  bit rand_ready = 1'b0;

  // expected levels per frame for a full fade cycle (step 2, one frame/step)
  int lv[19] = '{16, 16, 14, 12, 10, 8, 6, 4, 2, 0, 0, 2, 4, 6, 8, 10, 12, 14, 16};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [29:0] scale_pix(input logic [29:0] d, input int lvl);
    logic [29:0] r;
    int c8;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      c8 = int'(d[c*10+2 +: 8]);
      r[c*10+2 +: 8] = 8'((c8 * lvl) / 16);
    end
    return r;
  endfunction

  // driver tasks
  task automatic send_beat(input logic [29:0] d, input logic sop, input logic eop);
    bit r;
    int n;
    snk_data = d;
    snk_startofpacket = sop;
    snk_endofpacket = eop;
    snk_valid = 1'b1;
    exp_q.push_back({sop, eop, scale_pix(d, exp_level)});
    n = 0;
    forever begin
      @(negedge clk);
      r = snk_ready;
      @(posedge clk);
      #1;
      src_ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
      if (r) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    snk_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [29:0] d, input int eop_at, input bit chk_first,
                            input logic [29:0] first_exp);
    for (int i = 0; i <= eop_at; i++) begin
      send_beat(d, (i == 0), (i == eop_at));
      if (i == 0 && chk_first) check("first_beat_data", {2'b0, src_data}, {2'b0, first_exp});
    end
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    src_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    snk_valid = 1'b0;
    snk_startofpacket = 1'b0;
    snk_endofpacket = 1'b0;
    reset_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    exp_q.delete();
    exp_level = 16;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_level", 32'(dbg_level), 32'd16);
    check("rst_face_select", 32'(face_select), 32'd0);
    check("rst_src_valid", 32'(src_valid), 32'd0);
    check("rst_src_data", {2'b0, src_data}, 32'd0);
    check("rst_src_sop_eop", {30'd0, src_startofpacket, src_endofpacket}, 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_fade_busy", 32'(fade_busy), 32'd0);
    reset_n = 1'b1;
  endtask

  // output monitor: ordering against the expected queue, and hold-while-stalled
  logic        prev_stall = 1'b0;
  logic [31:0] prev_val = '0;
  logic [31:0] e;
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && prev_stall) begin
        check("hold_beat", {src_startofpacket, src_endofpacket, src_data}, prev_val);
        check("hold_valid", 32'(src_valid), 32'd1);
      end
      if (reset_n && src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_beat", {src_startofpacket, src_endofpacket, src_data}, e);
        end
      end
      prev_stall = reset_n && src_valid && !src_ready;
      prev_val = {src_startofpacket, src_endofpacket, src_data};
    end
  end

  // main sequence
  logic [29:0] rd;
  initial begin
    reset_n = 1'b0;
    face_request = 2'd0;
    snk_data = '0;
    snk_startofpacket = 1'b0;
    snk_endofpacket = 1'b0;
    snk_valid = 1'b0;
    src_ready = 1'b1;
    do_reset(2);

    // 1: pass-through at full level, one-cycle latency
    for (int i = 0; i < 32; i++) begin
      send_beat(PAT1, ((i % NPIX) == 0), ((i % NPIX) == NPIX - 1));
      check("t1_valid", 32'(src_valid), 32'd1);
      check("t1_data", {2'b0, src_data}, {2'b0, PAT1});
      check("t1_sop_eop", {30'd0, src_startofpacket, src_endofpacket},
            {30'd0, ((i % NPIX) == 0), ((i % NPIX) == NPIX - 1)});
      check("t1_busy", 32'(fade_busy), 32'd0);
    end
    drain();

    // 2: random backpressure, ~1000 beats of random pixels
    rand_ready = 1'b1;
    for (int f = 0; f < 63; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        rd = 30'($urandom()) & PAD_MASK;
        send_beat(rd, (i == 0), (i == NPIX - 1));
      end
    end
    drain();
    check("t2_state", 32'(dbg_state), 32'd0);
    check("t2_frame_error", 32'(frame_error), 32'd0);

    // 3: full fade cycle toward face 1
    face_request = 2'd1;
    do_reset(1);
    for (int f = 0; f < 19; f++) begin
      exp_level = lv[f];
      check("t3_level", 32'(dbg_level), 32'(lv[f]));
      check("t3_busy", 32'(fade_busy), 32'((f >= 1) && (f <= 17)));
      check("t3_face_select", 32'(face_select), (f >= 10) ? 32'd1 : 32'd0);
      if (f == 9) check("t3_swap_state", 32'(dbg_state), 32'd2);
      send_frame(WHITE, NPIX - 1, (f == 5), HALF);
    end
    drain();
    check("t3_end_state", 32'(dbg_state), 32'd0);
    check("t3_end_face", 32'(face_select), 32'd1);
    check("t3_end_busy", 32'(fade_busy), 32'd0);
    check("t3_frame_error", 32'(frame_error), 32'd0);

    // 4: reset in the middle of a fade-out at level 6
    face_request = 2'd1;
    do_reset(1);
    for (int f = 0; f < 6; f++) begin
      exp_level = lv[f];
      send_frame(WHITE, NPIX - 1, 1'b0, '0);
    end
    check("t4_level6", 32'(dbg_level), 32'd6);
    check("t4_fade_out", 32'(dbg_state), 32'd1);
    exp_level = 6;
    for (int i = 0; i < 5; i++) send_beat(WHITE, (i == 0), 1'b0);
    src_ready = 1'b1;
    @(negedge clk);
    face_request = 2'd0;
    do_reset(1);

    // 5: misplaced EOP sets the sticky framing error; data still forwarded
    send_frame(PAT1, NPIX - 1, 1'b0, '0);
    check("t5_no_error", 32'(frame_error), 32'd0);
    send_frame(PAT1, 10, 1'b0, '0);
    check("t5_error_set", 32'(frame_error), 32'd1);
    check("t5_short_eop_data", {src_endofpacket, src_data}, {1'b1, PAT1});
    send_frame(WHITE, NPIX - 1, 1'b0, '0);
    check("t5_error_sticky", 32'(frame_error), 32'd1);
    check("t5_state", 32'(dbg_state), 32'd0);
    drain();

    // 6: request 2, then back to 0 before the swap frame
    do_reset(1);
    face_request = 2'd2;
    for (int f = 0; f < 19; f++) begin
      if (f == 2) face_request = 2'd0;
      if (f == 4) face_request = 2'd2;
      if (f == 6) face_request = 2'd0;
      exp_level = lv[f];
      check("t6_level", 32'(dbg_level), 32'(lv[f]));
      check("t6_face_select", 32'(face_select), 32'd0);
      if (f == 9) check("t6_swap_state", 32'(dbg_state), 32'd2);
      send_frame(WHITE, NPIX - 1, 1'b0, '0);
    end
    check("t6_end_state", 32'(dbg_state), 32'd0);
    check("t6_end_face", 32'(face_select), 32'd0);
    exp_level = 16;
    send_frame(WHITE, NPIX - 1, 1'b0, '0);
    check("t6_stays_show", 32'(dbg_state), 32'd0);
    check("t6_stays_level", 32'(dbg_level), 32'd16);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
